spi_cmd_decoder: RTL

- Serial command front end of the flash model; sits directly upstream of the sector protection register.
- Shifts opcode and 24-bit address in from the SPI pins and drives the protection block's `addr`, `prot`, `unprot` and `r_sector` inputs.
- Manages the write-enable latch that gates protect/unprotect commands.
- Shifts the 8-bit protection status byte back out on SO for the read-protection command.

---
 rtl/spi_cmd_decoder_if.sv | 26 ++
 rtl/spi_cmd_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder_if.sv
// SPI pin and protection-block signal bundle for spi_cmd_decoder.
// master = SPI host / protection block side, slave = decoder side.
`timescale 1ns/1ps
interface spi_cmd_decoder_if;
  logic        cs;
  logic        si;
  logic [7:0]  prot_data_in;
  logic        so;
  logic        so_oe;
  logic [31:0] addr;
  logic        prot;
  logic        unprot;
  logic        r_sector;
  logic        wel;
  logic [7:0]  opcode;

  modport master (
    output cs, si, prot_data_in,
    input  so, so_oe, addr, prot, unprot, r_sector, wel, opcode
  );

  modport slave (
    input  cs, si, prot_data_in,
    output so, so_oe, addr, prot, unprot, r_sector, wel, opcode
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI mode-0 command decoder feeding the sector protection register.
// Optional feature macro: SPI_DECODER_WEL_EN (write-enable latch gating of protect/unprotect).
`timescale 1ns/1ps
module spi_cmd_decoder #(
  parameter int ADDR_BITS = 24
) (
  input  logic               sck,
  input  logic               rst_n,
  spi_cmd_decoder_if.slave   bus
);

  localparam logic [7:0] OP_WREN      = 8'h06;
  localparam logic [7:0] OP_WRDI      = 8'h04;
  localparam logic [7:0] OP_PROTECT   = 8'h36;
  localparam logic [7:0] OP_UNPROTECT = 8'h39;
  localparam logic [7:0] OP_READ_PROT = 8'h3C;
  localparam logic [5:0] LAST_CNT     = 6'(ADDR_BITS + 7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_ABORT
  } state_t;

  state_t                 r_state;
  logic [5:0]             r_cnt;
  logic [6:0]             r_opc_sh;
  logic                   r_rsec;
  logic [7:0]             r_opcode;
  logic [ADDR_BITS-1:0]   r_addr;
  logic                   r_prot;
  logic                   r_unprot;
  logic                   r_so;
  logic [6:0]             r_so_sh;
  logic [2:0]             r_so_cnt;

  logic                   w_clr_n;
  logic [7:0]             w_opc_in;
  logic                   w_opc_done;
  logic                   w_last_addr;
  logic                   w_wel;

  // Deselect (cs high) clears the per-command state just like reset does.
  assign w_clr_n     = rst_n & ~bus.cs;
  assign w_opc_in    = {r_opc_sh, bus.si};
  assign w_opc_done  = (r_state == S_OPC) && (r_cnt == 6'd7);
  assign w_last_addr = (r_state == S_ADDR) && (r_cnt == LAST_CNT);

  always_ff @(posedge sck or negedge w_clr_n) begin
    if (!w_clr_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_opc_sh <= 7'd0;
      r_rsec   <= 1'b0;
    end else begin
      if (r_cnt != 6'd63) r_cnt <= r_cnt + 6'd1;
      case (r_state)
        S_IDLE: begin
          r_opc_sh <= {r_opc_sh[5:0], bus.si};
          r_state  <= S_OPC;
        end
        S_OPC: begin
          r_opc_sh <= {r_opc_sh[5:0], bus.si};
          if (r_cnt == 6'd7) begin
            case (w_opc_in)
              OP_WREN, OP_WRDI:                      r_state <= S_DONE;
              OP_PROTECT, OP_UNPROTECT, OP_READ_PROT: r_state <= S_ADDR;
              default:                               r_state <= S_OPC;
            endcase
          end
        end
        S_ADDR: begin
          if (r_cnt == LAST_CNT) begin
            if (r_opcode == OP_READ_PROT) begin
              r_state <= S_DATA;
              r_rsec  <= 1'b1;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        // Any clock past a complete command invalidates it.
        S_DONE:  r_state <= S_ABORT;
        S_DATA:  r_state <= S_DATA;
        S_ABORT: r_state <= S_ABORT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Results that must survive the cs rise live outside the cs-cleared domain.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= 8'h00;
      r_addr   <= '0;
      r_prot   <= 1'b0;
      r_unprot <= 1'b0;
    end else begin
      if (w_opc_done) r_opcode <= w_opc_in;
      if (r_state == S_ADDR) r_addr <= {r_addr[ADDR_BITS-2:0], bus.si};
      r_prot   <= w_last_addr && (r_opcode == OP_PROTECT)   && w_wel;
      r_unprot <= w_last_addr && (r_opcode == OP_UNPROTECT) && w_wel;
    end
  end

`ifdef SPI_DECODER_WEL_EN
  logic r_wel;
  logic r_wren_done;
  logic r_wrdi_done;
  logic r_pu_done;

  // Each flag is true only while the command sits exactly at its completion edge count.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_wren_done <= 1'b0;
      r_wrdi_done <= 1'b0;
      r_pu_done   <= 1'b0;
    end else begin
      r_wren_done <= w_opc_done && (w_opc_in == OP_WREN);
      r_wrdi_done <= w_opc_done && (w_opc_in == OP_WRDI);
      r_pu_done   <= w_last_addr &&
                     ((r_opcode == OP_PROTECT) || (r_opcode == OP_UNPROTECT));
    end
  end

  always_ff @(posedge bus.cs or negedge rst_n) begin
    if (!rst_n) begin
      r_wel <= 1'b0;
    end else if (r_wren_done) begin
      r_wel <= 1'b1;
    end else if (r_wrdi_done || r_pu_done) begin
      r_wel <= 1'b0;
    end
  end

  assign w_wel = r_wel;
`else
  assign w_wel = 1'b1;
`endif

  // Status byte is (re)loaded every 8 falling edges, first load on the falling edge after the last address bit.
  always_ff @(negedge sck or negedge w_clr_n) begin
    if (!w_clr_n) begin
      r_so     <= 1'b0;
      r_so_sh  <= 7'd0;
      r_so_cnt <= 3'd0;
    end else if (r_state == S_DATA) begin
      if (r_so_cnt == 3'd0) begin
        r_so    <= bus.prot_data_in[7];
        r_so_sh <= bus.prot_data_in[6:0];
      end else begin
        r_so    <= r_so_sh[6];
        r_so_sh <= {r_so_sh[5:0], 1'b0};
      end
      r_so_cnt <= r_so_cnt + 3'd1;
    end
  end

  assign bus.so       = r_so;
  assign bus.so_oe    = r_rsec;
  assign bus.r_sector = r_rsec;
  assign bus.addr     = 32'(r_addr);
  assign bus.prot     = r_prot;
  assign bus.unprot   = r_unprot;
  assign bus.wel      = w_wel;
  assign bus.opcode   = r_opcode;

endmodule
